decode_stage_pipe: RTL and testbench

DECODE_STAGE_PIPE -- requirements
Module: decode_stage_pipe

---
 rtl/decode_stage_pipe.sv | 144 ++++++++++++++
 tb/tb_decode_stage_pipe.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: RV32I decode stage with ID/EX register, load-use stall, flush and stall counter
// Ports: clk, rstn (async active-low); in_valid/in_ready/in_pc/in_instr from IF;
//   flush kills held and offered instructions; ex_ready is EX backpressure; ex_ld_valid/ex_ld_rd
//   describe a load in EX; out_* is the registered decode; stall_cnt counts stalled cycles (saturating).
module decode_stage_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [31:0]      in_instr,
  input  logic             flush,
  input  logic             ex_ready,
  input  logic             ex_ld_valid,
  input  logic [4:0]       ex_ld_rd,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic [4:0]       out_alu_op,
  output logic             out_alu_src,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic [2:0]       out_dm_type,
  output logic [1:0]       out_wd_sel,
  output logic             out_illegal,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam int DW = 2*XLEN + 30;
  logic [6:0]        w_op;
  logic [2:0]        w_f3;
  logic signed [31:0] w_imm32;
  logic [XLEN-1:0]   w_imm;
  logic [4:0]        w_alu_op;
  logic              w_alu_src, w_reg_write, w_mem_read, w_mem_write, w_illegal;
  logic [2:0]        w_dm_type;
  logic [1:0]        w_wd_sel;
  logic              w_uses_rs1, w_uses_rs2, w_hazard, w_take;
  logic [DW-1:0]     r_dec;
  logic              r_valid;
  logic [CNT_W-1:0]  r_stall;
  assign w_op  = in_instr[6:0];
  assign w_f3  = in_instr[14:12];
  assign w_imm = XLEN'(w_imm32);
  always_comb begin
    w_imm32     = '0;
    w_alu_op    = '0;
    w_alu_src   = 1'b0;
    w_reg_write = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_dm_type   = '0;
    w_wd_sel    = '0;
    w_illegal   = 1'b0;
    case (w_op)
      OP_R: begin
        w_alu_op    = {1'b0, in_instr[30], w_f3};
        w_reg_write = 1'b1;
      end
      OP_I: begin
        w_imm32     = {{20{in_instr[31]}}, in_instr[31:20]};
        w_alu_op    = {1'b0, (w_f3 == 3'b101) & in_instr[30], w_f3};
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
      end
      OP_LD: begin
        w_imm32     = {{20{in_instr[31]}}, in_instr[31:20]};
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
        w_mem_read  = 1'b1;
        w_dm_type   = w_f3;
        w_wd_sel    = 2'd1;
      end
      OP_ST: begin
        w_imm32     = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
        w_dm_type   = w_f3;
      end
      OP_BR: begin
        w_imm32  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
        w_alu_op = {2'b11, w_f3};
      end
      OP_JAL: begin
        w_imm32     = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
        w_reg_write = 1'b1;
        w_wd_sel    = 2'd2;
      end
      OP_JALR: begin
        w_imm32     = {{20{in_instr[31]}}, in_instr[31:20]};
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
        w_wd_sel    = 2'd2;
      end
      OP_LUI: begin
        w_imm32     = {in_instr[31:12], 12'b0};
        w_alu_op    = 5'b10000;
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
      end
      OP_AUIPC: begin
        w_imm32     = {in_instr[31:12], 12'b0};
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end
  assign w_uses_rs1 = ~(w_op == OP_LUI || w_op == OP_AUIPC || w_op == OP_JAL);
  assign w_uses_rs2 = w_op == OP_R || w_op == OP_ST || w_op == OP_BR;
  assign w_hazard   = in_valid & ex_ld_valid & (ex_ld_rd != 5'd0) &
                      ((w_uses_rs1 & (in_instr[19:15] == ex_ld_rd)) |
                       (w_uses_rs2 & (in_instr[24:20] == ex_ld_rd)));
  // Gated by rstn so the stage never advertises acceptance while held in reset.
  assign in_ready = rstn & (flush | (~w_hazard & (~r_valid | ex_ready)));
  assign w_take   = in_valid & in_ready & ~flush;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_dec   <= '0;
      r_stall <= '0;
    end else begin
      r_valid <= ~flush & (w_take | (r_valid & ~ex_ready));
      if (w_take)
        r_dec <= {in_pc, in_instr[19:15], in_instr[24:20], in_instr[11:7], w_imm, w_alu_op,
                  w_alu_src, w_reg_write & ~w_illegal, w_mem_read, w_mem_write, w_dm_type, w_wd_sel, w_illegal};
      if (in_valid & ~in_ready & ~&r_stall)
        r_stall <= r_stall + 1'b1;
    end
  end
  assign {out_pc, out_rs1, out_rs2, out_rd, out_imm, out_alu_op, out_alu_src, out_reg_write,
          out_mem_read, out_mem_write, out_dm_type, out_wd_sel, out_illegal} = r_dec;
  assign out_valid = r_valid;
  assign stall_cnt = r_stall;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb_decode_stage_pipe: checks an XLEN=32 and an XLEN=64/CNT_W=3 decode stage driven in lockstep
module tb_decode_stage_pipe;
  logic        clk, rstn, in_valid, flush, ex_ready, ex_ld_valid;
  logic [4:0]  ex_ld_rd;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        r32, v32, src32, rw32, mr32, mw32, il32;
  logic [31:0] pc32, imm32;
  logic [4:0]  rs1_32, rs2_32, rd_32, alu32;
  logic [2:0]  dm32;
  logic [1:0]  wd32;
  logic [15:0] sc32;
  logic        r64, v64, src64, rw64, mr64, mw64, il64;
  logic [63:0] pc64, imm64;
  logic [4:0]  rs1_64, rs2_64, rd_64, alu64;
  logic [2:0]  dm64;
  logic [1:0]  wd64;
  logic [2:0]  sc64;
  decode_stage_pipe #(.XLEN(32), .CNT_W(16)) d32 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(r32), .in_pc(in_pc[31:0]),
    .in_instr(in_instr), .flush(flush), .ex_ready(ex_ready), .ex_ld_valid(ex_ld_valid),
    .ex_ld_rd(ex_ld_rd), .out_valid(v32), .out_pc(pc32), .out_rs1(rs1_32), .out_rs2(rs2_32),
    .out_rd(rd_32), .out_imm(imm32), .out_alu_op(alu32), .out_alu_src(src32),
    .out_reg_write(rw32), .out_mem_read(mr32), .out_mem_write(mw32), .out_dm_type(dm32),
    .out_wd_sel(wd32), .out_illegal(il32), .stall_cnt(sc32));
  decode_stage_pipe #(.XLEN(64), .CNT_W(3)) d64 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(r64), .in_pc(in_pc),
    .in_instr(in_instr), .flush(flush), .ex_ready(ex_ready), .ex_ld_valid(ex_ld_valid),
    .ex_ld_rd(ex_ld_rd), .out_valid(v64), .out_pc(pc64), .out_rs1(rs1_64), .out_rs2(rs2_64),
    .out_rd(rd_64), .out_imm(imm64), .out_alu_op(alu64), .out_alu_src(src64),
    .out_reg_write(rw64), .out_mem_read(mr64), .out_mem_write(mw64), .out_dm_type(dm64),
    .out_wd_sel(wd64), .out_illegal(il64), .stall_cnt(sc64));
  typedef struct packed {
    logic valid; logic [63:0] pc; logic [4:0] rs1, rs2, rd; logic [63:0] imm;
    logic [4:0] alu; logic src, rw, mr, mw; logic [2:0] dm; logic [1:0] wd; logic ill;
  } obs_t;
  typedef struct packed {
    logic [63:0] imm; logic [4:0] alu; logic src, rw, mr, mw; logic [2:0] dm; logic [1:0] wd;
    logic ill, u1, u2;
  } dec_t;
  typedef struct packed { logic [31:0] instr; logic [63:0] imm; logic [14:0] ctl; } vec_t;
  obs_t a32, a64;
  assign a32 = {v32, 32'b0, pc32, rs1_32, rs2_32, rd_32, 32'b0, imm32, alu32, src32, rw32, mr32, mw32, dm32, wd32, il32};
  assign a64 = {v64, pc64, rs1_64, rs2_64, rd_64, imm64, alu64, src64, rw64, mr64, mw64, dm64, wd64, il64};
  int          n_vec = 0, n_err = 0;
  bit          m_valid;
  logic [31:0] m_instr;
  logic [63:0] m_pc;
  int          m_stall;
  vec_t        tv [13];
  logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [159:0] a, logic [159:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  // Reference decode built straight from the RV32I format rules.
  function automatic dec_t decode(logic [31:0] i);
    dec_t d;
    logic [2:0] f3;
    d  = '0;
    f3 = i[14:12];
    case (i[6:0])
      7'h33: begin d.alu = {1'b0, i[30], f3}; d.rw = 1; end
      7'h13: begin d.imm = {{52{i[31]}}, i[31:20]}; d.alu = {1'b0, f3 == 3'd5 && i[30], f3}; d.src = 1; d.rw = 1; end
      7'h03: begin d.imm = {{52{i[31]}}, i[31:20]}; d.src = 1; d.rw = 1; d.mr = 1; d.dm = f3; d.wd = 1; end
      7'h23: begin d.imm = {{52{i[31]}}, i[31:25], i[11:7]}; d.src = 1; d.mw = 1; d.dm = f3; end
      7'h63: begin d.imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}; d.alu = {2'b11, f3}; end
      7'h6F: begin d.imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}; d.rw = 1; d.wd = 2; end
      7'h67: begin d.imm = {{52{i[31]}}, i[31:20]}; d.src = 1; d.rw = 1; d.wd = 2; end
      7'h37: begin d.imm = {{32{i[31]}}, i[31:12], 12'h0}; d.alu = 5'd16; d.src = 1; d.rw = 1; end
      7'h17: begin d.imm = {{32{i[31]}}, i[31:12], 12'h0}; d.src = 1; d.rw = 1; end
      default: d.ill = 1;
    endcase
    d.u1 = !(i[6:0] == 7'h37 || i[6:0] == 7'h17 || i[6:0] == 7'h6F);
    d.u2 = i[6:0] == 7'h33 || i[6:0] == 7'h23 || i[6:0] == 7'h63;
    return d;
  endfunction
  function automatic bit m_ready();
    dec_t d;
    bit   hz;
    d  = decode(in_instr);
    hz = in_valid && ex_ld_valid && ex_ld_rd != 0 &&
         ((d.u1 && in_instr[19:15] == ex_ld_rd) || (d.u2 && in_instr[24:20] == ex_ld_rd));
    return flush || (!hz && (!m_valid || ex_ready));
  endfunction
  function automatic obs_t m_obs(bit w32);
    dec_t d;
    obs_t o;
    d = decode(m_instr);
    o = {m_valid, w32 ? {32'b0, m_pc[31:0]} : m_pc, m_instr[19:15], m_instr[24:20], m_instr[11:7],
         w32 ? {32'b0, d.imm[31:0]} : d.imm, d.alu, d.src, d.rw, d.mr, d.mw, d.dm, d.wd, d.ill};
    return o;
  endfunction
  task automatic model_step();
    bit rdy;
    rdy = m_ready();
    if (in_valid && !rdy) m_stall++;
    if (flush) m_valid = 0;
    else if (in_valid && rdy) begin
      m_valid = 1;
      m_instr = in_instr;
      m_pc    = in_pc;
    end else if (ex_ready) m_valid = 0;
  endtask
  task automatic cmp_outs();
    if (m_valid) begin
      chk("out32", {1'b0, a32}, {1'b0, m_obs(1)});
      chk("out64", {1'b0, a64}, {1'b0, m_obs(0)});
    end else begin
      chk("valid32", 160'(v32), 160'(0));
      chk("valid64", 160'(v64), 160'(0));
    end
    chk("stall32", 160'(sc32), 160'(m_stall > 65535 ? 65535 : m_stall));
    chk("stall64", 160'(sc64), 160'(m_stall > 7 ? 7 : m_stall));
  endtask
  task automatic drive(bit v, logic [31:0] ins, bit fl, bit er, bit lv, logic [4:0] lr);
    in_valid = v; in_instr = ins; flush = fl; ex_ready = er; ex_ld_valid = lv; ex_ld_rd = lr;
    in_pc = {$urandom, $urandom};
  endtask
  task automatic cycle();
    #1;
    chk("rdy32", 160'(r32), 160'(m_ready()));
    chk("rdy64", 160'(r64), 160'(m_ready()));
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_outs();
  endtask
  // Asserts rstn between edges, with flush and an offer pending, and checks the async clear.
  task automatic do_reset(string nm);
    #2;
    drive(1, 32'h00728333, 1, 1, 1, 5'd5);
    rstn = 0;
    #1;
    chk({nm, ".out32"}, {1'b0, a32}, 160'(0));
    chk({nm, ".out64"}, {1'b0, a64}, 160'(0));
    chk({nm, ".cnt"}, 160'({sc32, sc64}), 160'(0));
    chk({nm, ".rdy"}, 160'({r32, r64}), 160'(0));
    m_valid = 0;
    m_stall = 0;
    @(negedge clk);
    rstn = 1;
  endtask
  task automatic rand_run(int n);
    logic [31:0] ins;
    int          pick;
    for (int k = 0; k < n; k++) begin
      ins  = $urandom;
      pick = $urandom_range(0, 10);
      if (pick < 9) ins[6:0] = ops[pick];
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      drive($urandom_range(0, 3) != 0, ins, $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 1) != 0, 5'($urandom_range(0, 3)));
      cycle();
    end
  endtask
  initial begin
    tv = '{
      '{32'hFFF00293, 64'hFFFF_FFFF_FFFF_FFFF, {5'd0,  4'b1100, 3'd0, 2'd0, 1'b0}},
      '{32'h00728333, 64'h0,                   {5'd0,  4'b0100, 3'd0, 2'd0, 1'b0}},
      '{32'h403100B3, 64'h0,                   {5'd8,  4'b0100, 3'd0, 2'd0, 1'b0}},
      '{32'h40315093, 64'h403,                 {5'd13, 4'b1100, 3'd0, 2'd0, 1'b0}},
      '{32'h40010093, 64'h400,                 {5'd0,  4'b1100, 3'd0, 2'd0, 1'b0}},
      '{32'hFFC12083, 64'hFFFF_FFFF_FFFF_FFFC, {5'd0,  4'b1110, 3'd2, 2'd1, 1'b0}},
      '{32'h00312423, 64'h8,                   {5'd0,  4'b1001, 3'd2, 2'd0, 1'b0}},
      '{32'hFE208CE3, 64'hFFFF_FFFF_FFFF_FFF8, {5'd24, 4'b0000, 3'd0, 2'd0, 1'b0}},
      '{32'h001000EF, 64'h800,                 {5'd0,  4'b0100, 3'd0, 2'd2, 1'b0}},
      '{32'h00008067, 64'h0,                   {5'd0,  4'b1100, 3'd0, 2'd2, 1'b0}},
      '{32'h800000B7, 64'hFFFF_FFFF_8000_0000, {5'd16, 4'b1100, 3'd0, 2'd0, 1'b0}},
      '{32'h12345117, 64'h1234_5000,           {5'd0,  4'b1100, 3'd0, 2'd0, 1'b0}},
      '{32'h0000007F, 64'h0,                   {5'd0,  4'b0000, 3'd0, 2'd0, 1'b1}}
    };
    rstn = 0;
    drive(1, 32'h00728333, 1, 0, 1, 5'd5);
    #2;
    chk("por.out32", {1'b0, a32}, 160'(0));
    chk("por.out64", {1'b0, a64}, 160'(0));
    chk("por.rdy", 160'({r32, r64}), 160'(0));
    m_valid = 0;
    m_stall = 0;
    @(negedge clk);
    rstn = 1;
    for (int k = 0; k < 13; k++) begin
      drive(1, tv[k].instr, 0, 1, 0, 5'd0);
      cycle();
      chk($sformatf("tv%0d.valid", k), 160'({v32, v64}), 160'(2'b11));
      chk($sformatf("tv%0d.imm64", k), 160'(imm64), 160'(tv[k].imm));
      chk($sformatf("tv%0d.imm32", k), 160'(imm32), 160'(tv[k].imm[31:0]));
      chk($sformatf("tv%0d.ctl32", k), 160'({alu32, src32, rw32, mr32, mw32, dm32, wd32, il32}), 160'(tv[k].ctl));
      chk($sformatf("tv%0d.ctl64", k), 160'({alu64, src64, rw64, mr64, mw64, dm64, wd64, il64}), 160'(tv[k].ctl));
    end
    do_reset("rst0");
    drive(1, 32'h00728333, 0, 1, 1, 5'd5);
    #1 chk("lu.rdy", 160'(r32), 160'(0));
    cycle();
    chk("lu.bubble", 160'(v32), 160'(0));
    chk("lu.stall", 160'(sc32), 160'(1));
    drive(1, 32'h00728333, 0, 1, 0, 5'd5);
    #1 chk("lu.rdy2", 160'(r32), 160'(1));
    cycle();
    chk("lu.valid", 160'(v32), 160'(1));
    chk("lu.rs1", 160'(rs1_32), 160'(5));
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'hFFF00293, 0, 0, 0, 5'd0);
      #1 chk("bp.rdy", 160'(r32), 160'(0));
      cycle();
      chk("bp.hold", 160'({v32, rs1_32, rs2_32, rd_32}), 160'({1'b1, 5'd5, 5'd7, 5'd6}));
    end
    chk("bp.stall", 160'(sc32), 160'(4));
    drive(1, 32'h00728333, 1, 0, 1, 5'd5);
    #1 chk("fl.rdy", 160'(r32), 160'(1));
    cycle();
    chk("fl.valid", 160'(v32), 160'(0));
    chk("fl.stall", 160'(sc32), 160'(4));
    drive(0, 32'h00728333, 0, 1, 0, 5'd0);
    cycle();
    chk("fl.empty", 160'(v32), 160'(0));
    drive(1, 32'hFFF00293, 0, 1, 0, 5'd0);
    cycle();
    for (int k = 0; k < 6; k++) begin
      drive(1, 32'h00728333, 0, 0, 0, 5'd0);
      cycle();
    end
    chk("sat.s32", 160'(sc32), 160'(10));
    chk("sat.s64", 160'(sc64), 160'(7));
    rand_run(3000);
    do_reset("rst1");
    rand_run(500);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
